apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Converts a simple valid/ready command stream into APB4 transfers: drives the SETUP and ACCESS phases, waits for PREADY, and returns PRDATA/PSLVERR on a valid/ready response channel.
- Acts as the initiator paired with the team's single-cycle APB memory slave.
- Serves as the stimulus-side RTL for subsystem benches.
- Handles one outstanding transfer at a time.

Parameters:
ADDR_WIDTH, 8, width of paddr and cmd_addr
DATA_WIDTH, 32, width of pwdata/prdata and the command/response data
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait cycles (used only with the optional feature; must be >= 1)

Ports:
pclk  in  1  clock; all logic on the rising edge
preset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  bridge accepts command
cmd_addr  in  ADDR_WIDTH  transfer address
cmd_write  in  1  1 = write, 0 = read
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  STRB_WIDTH  write byte strobes
rsp_valid  out  1  response held
rsp_ready  in  1  consumer takes response
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_slverr  out  1  transfer error
paddr  out  ADDR_WIDTH  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  STRB_WIDTH  APB strobes
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error

Behaviour:
- Interface: one clock, pclk; reset preset is asynchronous and active-high.
- Reset (async assert, sync release):
  - state = IDLE.
  - All APB outputs 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_slverr = 0.
  - cmd_ready = 0 while preset is high.
- All APB outputs and response outputs are registered.
- cmd_ready = (state == IDLE) && !preset; this is combinational from state only.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On cmd_valid && cmd_ready: capture command into paddr/pwrite/pwdata/pstrb, set psel=1, penable=0, go to SETUP.
  - For reads, pstrb = 0 and pwdata = 0.
- SETUP: always lasts exactly one cycle. Set penable=1 and go to ACCESS.
- ACCESS:
  - If pready=0: hold all APB outputs stable and stay in ACCESS.
  - If pready=1: set psel=0 and penable=0, capture rsp_slverr=pslverr and rsp_rdata = (pwrite ? 0 : prdata), set rsp_valid=1, go to RESP.
  - Return paddr, pwrite, pwdata and pstrb to 0 when psel drops.
- RESP:
  - Hold the response until rsp_valid && rsp_ready, then set rsp_valid=0 and go to IDLE.
  - rsp_ready may already be high on the first RESP cycle; the handshake completes in that cycle.
- Latency with a zero-wait slave: accept at edge N, psel=1 at N+1, penable=1 at N+2, rsp_valid=1 at N+3. Minimum command spacing is 4 cycles.
- Protocol guarantees:
  - penable never high without psel.
  - Every ACCESS is preceded by exactly one SETUP.
  - psel and penable never rise in the same cycle.
  - No back-to-back ACCESS phases.
  - paddr, pwrite, pwdata and pstrb are stable from SETUP through the completing ACCESS.
- Ignored inputs:
  - cmd_* is ignored outside IDLE.
  - prdata and pslverr are sampled only on the completing ACCESS edge.
- Reset mid-transfer: psel and penable drop immediately. The in-flight command is discarded and no response is generated.
- pslverr=1 with pready=1 is reported unchanged; the bridge never retries.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A wait counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the counter equals TIMEOUT_CYCLES and pready is still 0, the bridge aborts: psel=0, penable=0, rsp_slverr=1, rsp_rdata = all ones (for reads and writes), go to RESP.
  - pready=1 in the same cycle as the limit completes normally; completion wins over abort.
- Without the macro: no counter exists, and ACCESS waits indefinitely for pready.

Decomposition:
- Shared package apb_pkg, containing:
  - The state enum apb_state_e (IDLE/SETUP/ACCESS/RESP).
  - apb_cmd_t struct (addr, write, wdata, strb) and apb_rsp_t struct (rdata, slverr).
  - Constant APB_ERR_RDATA = all ones.
- Single module; no sub-module is warranted. The timeout counter lives inline under the macro guard.

Test Plan:
- Write: cmd addr=0x10, wdata=0xDEADBEEF, strb=4'b1111, slave pready=1 → psel at N+1, penable at N+2, pwdata stable across both, rsp_valid at N+3 with slverr=0, rdata=0.
- Read after write: read addr=0x10 → rsp_rdata=0xDEADBEEF, pstrb=0 during the transfer, slverr=0.
- Wait states and backpressure: slave holds pready=0 for 3 ACCESS cycles, rsp_ready held low 2 cycles → APB signals frozen, penable high for 4 cycles, response held stable until the handshake.
- Error: read addr=0xFF with slave pslverr=1 → rsp_slverr=1, rsp_rdata=0xFFFFFFFF (slave pattern); bridge returns to IDLE and accepts the next command.
- Timeout (macro on, TIMEOUT_CYCLES=4): pready stuck low → abort after 4 wait cycles, rsp_slverr=1, rsp_rdata=0xFFFFFFFF. Macro off: still in ACCESS after 100 cycles.
- Reset mid-ACCESS: preset pulsed during ACCESS → psel, penable and rsp_valid go 0 asynchronously; first command after release is a clean SETUP→ACCESS.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB bridge types: FSM state encoding, command/response records and the abort read pattern.
package apb_pkg;

    localparam int unsigned APB_DEF_ADDR_W = 8;
    localparam int unsigned APB_DEF_DATA_W = 32;
    localparam int unsigned APB_MAX_DATA_W = 256;

    // Wide enough for any supported DATA_WIDTH; users slice the low bits.
    localparam logic [APB_MAX_DATA_W-1:0] APB_ERR_RDATA = '1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic [APB_DEF_ADDR_W-1:0]   addr;
        logic                        write;
        logic [APB_DEF_DATA_W-1:0]   wdata;
        logic [APB_DEF_DATA_W/8-1:0] strb;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DEF_DATA_W-1:0] rdata;
        logic                      slverr;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge.sv
// APB4 initiator: one valid/ready command in, SETUP/ACCESS on APB, one valid/ready response out.
// Defining APB_MASTER_TIMEOUT_EN adds an ACCESS-phase wait limit of TIMEOUT_CYCLES.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [STRB_WIDTH-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    apb_state_e            state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_slverr_q, rsp_slverr_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) wait_q <= '0;
        else        wait_q <= wait_d;
    end
`endif

    assign cmd_ready = (state_q == IDLE) && !preset;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q      <= IDLE;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        paddr_d      = paddr_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_slverr_d = rsp_slverr_q;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_d       = wait_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    pstrb_d  = cmd_write ? cmd_strb : '0;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                wait_d    = '0;
`endif
                state_d   = ACCESS;
            end
            ACCESS: begin
                // Completion is checked first so pready at the wait limit still finishes normally.
                if (pready) begin
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    paddr_d      = '0;
                    pwrite_d     = 1'b0;
                    pwdata_d     = '0;
                    pstrb_d      = '0;
                    rsp_valid_d  = 1'b1;
                    rsp_slverr_d = pslverr;
                    rsp_rdata_d  = pwrite_q ? '0 : prdata;
                    state_d      = RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (wait_q == WAIT_W'(TIMEOUT_CYCLES)) begin
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    paddr_d      = '0;
                    pwrite_d     = 1'b0;
                    pwdata_d     = '0;
                    pstrb_d      = '0;
                    rsp_valid_d  = 1'b1;
                    rsp_slverr_d = 1'b1;
                    rsp_rdata_d  = APB_ERR_RDATA[DATA_WIDTH-1:0];
                    state_d      = RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign psel       = psel_q;
    assign penable    = penable_q;
    assign paddr      = paddr_q;
    assign pwrite     = pwrite_q;
    assign pwdata     = pwdata_q;
    assign pstrb      = pstrb_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: byte-level memory model predicts responses; a task-driven APB slave supplies waits and errors.
// Define APB_MASTER_TIMEOUT_EN to exercise the ACCESS timeout (TIMEOUT_CYCLES=4).
module tb_apb_master_bridge;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned TO_CYC = 4;
`else
    localparam int unsigned TO_CYC = 16;
`endif

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic [7:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready, pslverr;

    int errors = 0;
    int checks = 0;

    logic [31:0] slv_mem   [256];
    logic [7:0]  ref_bytes [1024];

    apb_master_bridge #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32),
        .STRB_WIDTH(4),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, got=running exp=finished");
        $fatal(1, "watchdog");
    end

    // Reference: address 0xFF is the erroring location; others are plain byte-strobed memory.
    task automatic model_xfer(input logic [7:0] a, input logic w, input logic [31:0] wd,
                              input logic [3:0] st, output logic [31:0] rd, output logic err);
        rd  = '0;
        err = (a == 8'hFF);
        if (err) begin
            rd = w ? 32'h0 : 32'hFFFF_FFFF;
        end else if (w) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) ref_bytes[int'(a) * 4 + b] = wd[8*b +: 8];
        end else begin
            for (int b = 0; b < 4; b++) rd[8*b +: 8] = ref_bytes[int'(a) * 4 + b];
        end
    endtask

    task automatic drive_garbage();
        cmd_valid = 1'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_write = 1'($urandom);
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
    endtask

    task automatic slave_complete();
        logic [31:0] word;
        pready = 1'b1;
        if (paddr == 8'hFF) begin
            pslverr = 1'b1;
            prdata  = 32'hFFFF_FFFF;
        end else begin
            pslverr = 1'b0;
            word = slv_mem[paddr];
            if (pwrite) begin
                for (int b = 0; b < 4; b++) if (pstrb[b]) word[8*b +: 8] = pwdata[8*b +: 8];
                slv_mem[paddr] = word;
                prdata = $urandom;
            end else begin
                prdata = word;
            end
        end
    endtask

    task automatic do_xfer(input logic [7:0] a, input logic w, input logic [31:0] wd,
                           input logic [3:0] st, input int unsigned waits, input int unsigned rdelay);
        logic [31:0] exp_rd, exp_pwd;
        logic [3:0]  exp_pst;
        logic        exp_err;
        model_xfer(a, w, wd, st, exp_rd, exp_err);
        exp_pwd = w ? wd : 32'h0;
        exp_pst = w ? st : 4'h0;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL idle_ready got=%b exp=1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = wd; cmd_strb = st;
        rsp_ready = 1'b0; pready = 1'b0;
        @(posedge pclk); @(negedge pclk);
        drive_garbage();
        checks++;
        if ({psel, penable, paddr, pwrite, pwdata, pstrb, rsp_valid, cmd_ready} !==
            {2'b10, a, w, exp_pwd, exp_pst, 2'b00}) begin
            errors++;
            $display("FAIL setup_phase got=sel%b en%b a%h w%b d%h s%h rv%b cr%b exp=sel1 en0 a%h w%b d%h s%h rv0 cr0",
                     psel, penable, paddr, pwrite, pwdata, pstrb, rsp_valid, cmd_ready, a, w, exp_pwd, exp_pst);
        end
        @(posedge pclk); @(negedge pclk);
        drive_garbage();
        checks++;
        if ({psel, penable, paddr, pwrite, pwdata, pstrb, rsp_valid} !== {2'b11, a, w, exp_pwd, exp_pst, 1'b0}) begin
            errors++;
            $display("FAIL access_phase got=sel%b en%b a%h w%b d%h s%h rv%b exp=sel1 en1 a%h w%b d%h s%h rv0",
                     psel, penable, paddr, pwrite, pwdata, pstrb, rsp_valid, a, w, exp_pwd, exp_pst);
        end
        for (int unsigned i = 0; i < waits; i++) begin
            pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
            @(posedge pclk); @(negedge pclk);
            drive_garbage();
            checks++;
            if ({psel, penable, paddr, pwrite, pwdata, pstrb, rsp_valid} !== {2'b11, a, w, exp_pwd, exp_pst, 1'b0}) begin
                errors++;
                $display("FAIL wait_hold[%0d] got=sel%b en%b a%h w%b d%h s%h rv%b exp=sel1 en1 a%h w%b d%h s%h rv0",
                         i, psel, penable, paddr, pwrite, pwdata, pstrb, rsp_valid, a, w, exp_pwd, exp_pst);
            end
        end
        slave_complete();
        @(posedge pclk); @(negedge pclk);
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
        drive_garbage();
        checks++;
        if ({psel, penable, paddr, pwrite, pwdata, pstrb} !== 47'h0) begin
            errors++;
            $display("FAIL apb_release got=sel%b en%b a%h w%b d%h s%h exp=all zero",
                     psel, penable, paddr, pwrite, pwdata, pstrb);
        end
        for (int unsigned i = 0; i <= rdelay; i++) begin
            if (i > 0) begin
                @(posedge pclk); @(negedge pclk);
                drive_garbage();
            end
            checks++;
            if ({rsp_valid, rsp_rdata, rsp_slverr} !== {1'b1, exp_rd, exp_err}) begin
                errors++;
                $display("FAIL response[%0d] addr=%h got=v%b d%h e%b exp=v1 d%h e%b",
                         i, a, rsp_valid, rsp_rdata, rsp_slverr, exp_rd, exp_err);
            end
        end
        rsp_ready = 1'b1;
        @(posedge pclk); @(negedge pclk);
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++; $display("FAIL handshake_done got=rv%b cr%b exp=rv0 cr1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset();
        preset = 1'b1; cmd_valid = 1'b1; cmd_addr = 8'h55; cmd_write = 1'b1;
        cmd_wdata = 32'h1234_5678; cmd_strb = 4'hF; rsp_ready = 1'b0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        repeat (3) @(negedge pclk);
        checks++;
        if ({psel, penable, paddr, pwrite, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_slverr, cmd_ready} !== 82'h0) begin
            errors++;
            $display("FAIL reset_state got=sel%b en%b a%h w%b d%h s%h rv%b rd%h re%b cr%b exp=all zero",
                     psel, penable, paddr, pwrite, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_slverr, cmd_ready);
        end
        cmd_valid = 1'b0; preset = 1'b0;
        @(negedge pclk);
        checks++;
        if ({cmd_ready, psel} !== 2'b10) begin
            errors++; $display("FAIL reset_release got=cr%b sel%b exp=cr1 sel0", cmd_ready, psel);
        end
    endtask

    task automatic test_write_read();
        do_xfer(8'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 0);
        do_xfer(8'h10, 1'b0, 32'h0BAD_F00D, 4'hA, 0, 0);
    endtask

    task automatic test_wait_backpressure();
        do_xfer(8'h20, 1'b1, 32'hCAFE_0123, 4'b0101, 3, 2);
        do_xfer(8'h20, 1'b0, 32'h0, 4'h0, 3, 2);
    endtask

    task automatic test_error();
        do_xfer(8'hFF, 1'b0, 32'h0, 4'h0, 0, 0);
        do_xfer(8'hFF, 1'b1, 32'h7777_7777, 4'hF, 1, 1);
        do_xfer(8'h10, 1'b0, 32'h0, 4'h0, 0, 0);
    endtask

    task automatic test_timeout();
`ifdef APB_MASTER_TIMEOUT_EN
        cmd_valid = 1'b1; cmd_addr = 8'h30; cmd_write = 1'b1; cmd_wdata = 32'h1111_2222; cmd_strb = 4'hF;
        pready = 1'b0; rsp_ready = 1'b0;
        @(posedge pclk); @(negedge pclk); cmd_valid = 1'b0;
        @(posedge pclk); @(negedge pclk);
        for (int unsigned i = 0; i < TO_CYC; i++) begin
            @(posedge pclk); @(negedge pclk);
            checks++;
            if ({psel, penable, rsp_valid} !== 3'b110) begin
                errors++; $display("FAIL timeout_wait[%0d] got=sel%b en%b rv%b exp=sel1 en1 rv0", i, psel, penable, rsp_valid);
            end
        end
        @(posedge pclk); @(negedge pclk);
        checks++;
        if ({psel, penable, rsp_valid, rsp_slverr, rsp_rdata} !== {4'b0011, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL timeout_abort got=sel%b en%b rv%b e%b d%h exp=sel0 en0 rv1 e1 dffffffff",
                     psel, penable, rsp_valid, rsp_slverr, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(posedge pclk); @(negedge pclk); rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++; $display("FAIL timeout_done got=rv%b cr%b exp=rv0 cr1", rsp_valid, cmd_ready);
        end
        do_xfer(8'h31, 1'b1, 32'h5A5A_A5A5, 4'hF, TO_CYC, 0);
        do_xfer(8'h31, 1'b0, 32'h0, 4'h0, 0, 0);
`else
        do_xfer(8'h30, 1'b0, 32'h0, 4'h0, 100, 0);
`endif
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_addr = 8'h10; cmd_write = 1'b1; cmd_wdata = 32'h9999_9999; cmd_strb = 4'hF;
        pready = 1'b0; rsp_ready = 1'b0;
        @(posedge pclk); @(negedge pclk); cmd_valid = 1'b0;
        @(posedge pclk); @(negedge pclk);
        @(posedge pclk); @(negedge pclk);
        #2 preset = 1'b1;
        #1;
        checks++;
        if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid got=sel%b en%b rv%b cr%b exp=all zero", psel, penable, rsp_valid, cmd_ready);
        end
        @(negedge pclk); preset = 1'b0;
        @(negedge pclk);
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++; $display("FAIL reset_mid_release got=rv%b cr%b exp=rv0 cr1", rsp_valid, cmd_ready);
        end
        do_xfer(8'h10, 1'b0, 32'h0, 4'h0, 0, 0);
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 9) == 9) ? 8'hFF : 8'($urandom_range(0, 7));
            do_xfer(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) slv_mem[i] = '0;
        for (int i = 0; i < 1024; i++) ref_bytes[i] = '0;
        test_reset();
        test_write_read();
        test_wait_backpressure();
        test_error();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
